// File: rtl/dma_pkg.sv
// Shared types for the block-copy DMA initiator.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RW,
        WR
    } dma_state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Word block-copy engine: reads word k while writing word k-1, one word per cycle after fill.
// Overlapping ranges behave like a forward loop because memory forwards wdata on raddr==waddr.
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int unsigned NUMWORDS  = 4096,
    parameter int unsigned DATAWIDTH = 32,
    localparam int unsigned AW       = $clog2(NUMWORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AW-1:0]        src_i,
    input  logic [AW-1:0]        dst_i,
    input  logic [AW:0]          len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 re_o,
    output logic [AW-1:0]        raddr_o,
    input  logic [DATAWIDTH-1:0] rdata_i,
    output logic                 we_o,
    output logic [AW-1:0]        waddr_o,
    output logic [DATAWIDTH-1:0] wdata_o
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(NUMWORDS);
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    dma_state_e           r_state, w_state_d;
    logic [AW-1:0]        r_src, w_src_d;
    logic [AW-1:0]        r_dst, w_dst_d;
    logic [AW:0]          r_rem, w_rem_d;
    logic [DATAWIDTH-1:0] r_data, w_data_d;
    logic                 r_done, w_done_d;
    logic [AW:0]          w_len_sat;

    assign w_len_sat = (len_i > LEN_MAX) ? LEN_MAX : len_i;

    always_comb begin
        w_state_d = r_state;
        w_src_d   = r_src;
        w_dst_d   = r_dst;
        w_rem_d   = r_rem;
        w_data_d  = r_data;
        w_done_d  = 1'b0;
        busy_o    = 1'b0;
        re_o      = 1'b0;
        raddr_o   = '0;
        we_o      = 1'b0;
        waddr_o   = '0;
        wdata_o   = '0;

        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (w_len_sat != '0) begin
                        w_src_d   = src_i;
                        w_dst_d   = dst_i;
                        w_rem_d   = w_len_sat;
                        w_state_d = RD;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end
            end
            RD: begin
                busy_o    = 1'b1;
                re_o      = 1'b1;
                raddr_o   = r_src;
                w_data_d  = rdata_i;
                w_src_d   = r_src + 1'b1;
                w_rem_d   = r_rem - 1'b1;
                w_state_d = (r_rem != LEN_ONE) ? RW : WR;
            end
            RW: begin
                busy_o   = 1'b1;
                re_o     = 1'b1;
                raddr_o  = r_src;
                we_o     = 1'b1;
                waddr_o  = r_dst;
                wdata_o  = r_data;
                w_data_d = rdata_i;
                w_src_d  = r_src + 1'b1;
                w_dst_d  = r_dst + 1'b1;
                w_rem_d  = r_rem - 1'b1;
                // r_rem==1 means the word read now is the last one
                if (r_rem == LEN_ONE) begin
                    w_state_d = WR;
                end
            end
            WR: begin
                busy_o    = 1'b1;
                we_o      = 1'b1;
                waddr_o   = r_dst;
                wdata_o   = r_data;
                w_done_d  = 1'b1;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_src   <= w_src_d;
            r_dst   <= w_dst_d;
            r_rem   <= w_rem_d;
            r_data  <= w_data_d;
            r_done  <= w_done_d;
        end
    end

    assign done_o = r_done;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a forwarding single-cycle memory model.
module tb_mem_copy_dma;

    localparam int NW = 4096;
    localparam int DW = 32;
    localparam int AW = 12;

    typedef struct packed {
        int              src;
        int              dst;
        int              len;
        int              p_addr;
        int              p_n;
        logic [3:0][31:0] p_w;
        int              exp_busy;
        int              exp_ovl;
        int              c_addr;
        int              c_n;
        logic [3:0][31:0] c_w;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] src_i = '0;
    logic [AW-1:0] dst_i = '0;
    logic [AW:0]   len_i = '0;
    logic          busy_o, done_o, re_o, we_o;
    logic [AW-1:0] raddr_o, waddr_o;
    logic [DW-1:0] rdata_i, wdata_o;

    logic          pl_clr = 1'b0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] refm [NW];

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs [7];

    always #5 clk = ~clk;

    mem_copy_dma #(.NUMWORDS(NW), .DATAWIDTH(DW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .src_i   (src_i),
        .dst_i   (dst_i),
        .len_i   (len_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .re_o    (re_o),
        .raddr_o (raddr_o),
        .rdata_i (rdata_i),
        .we_o    (we_o),
        .waddr_o (waddr_o),
        .wdata_o (wdata_o)
    );

    assign rdata_i = (we_o && (waddr_o == raddr_o)) ? wdata_o : mem[raddr_o];

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < NW; i++) mem[i] <= 32'h5A5A_0000 | i;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (we_o) begin
            mem[waddr_o] <= wdata_o;
        end
    end

    function automatic logic [31:0] pat(input int a);
        return 32'h5A5A_0000 | a;
    endfunction

    function automatic vec_t mk(input int s, input int d, input int l, input int pa, input int pn,
                                input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3,
                                input int eb, input int eo, input int ca, input int cn,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.src = s; v.dst = d; v.len = l; v.p_addr = pa; v.p_n = pn;
        v.p_w[0] = p0; v.p_w[1] = p1; v.p_w[2] = p2; v.p_w[3] = p3;
        v.exp_busy = eb; v.exp_ovl = eo; v.c_addr = ca; v.c_n = cn;
        v.c_w[0] = e0; v.c_w[1] = e1; v.c_w[2] = e2; v.c_w[3] = e3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Fill memory and reference with the background pattern plus optional preload words.
    task automatic prep_mem(input int pa, input int pn, input logic [3:0][31:0] pw);
        @(negedge clk) pl_clr = 1'b1;
        @(negedge clk) pl_clr = 1'b0;
        for (int i = 0; i < NW; i++) refm[i] = pat(i);
        for (int i = 0; i < pn; i++) begin
            pl_en   = 1'b1;
            pl_addr = AW'((pa + i) % NW);
            pl_data = pw[i];
            refm[(pa + i) % NW] = pw[i];
            @(negedge clk);
        end
        pl_en = 1'b0;
    endtask

    task automatic cmp_image(input string nm);
        int bad = 0;
        for (int i = 0; i < NW; i++) if (mem[i] !== refm[i]) bad++;
        chk(nm, 64'(bad), 64'd0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int ls, busy_n, ovl_n, done_n, done_cyc, rd_k, wr_k, addr_err, data_err, tail;
        prep_mem(v.p_addr, v.p_n, v.p_w);
        ls = (v.len > NW) ? NW : v.len;
        for (int i = 0; i < ls; i++) refm[(v.dst + i) % NW] = refm[(v.src + i) % NW];
        @(negedge clk);
        start_i = 1'b1;
        src_i   = AW'(v.src);
        dst_i   = AW'(v.dst);
        len_i   = (AW+1)'(v.len);
        @(negedge clk);
        start_i = 1'b0;
        src_i   = ~src_i;
        dst_i   = ~dst_i;
        len_i   = 13'd3;
        busy_n = 0; ovl_n = 0; done_n = 0; done_cyc = -1;
        rd_k = 0; wr_k = 0; addr_err = 0; data_err = 0; tail = -1;
        for (int cyc = 1; cyc < 5000; cyc++) begin
            if (busy_o) busy_n++;
            if (re_o && we_o) ovl_n++;
            if (re_o) begin
                if (int'(raddr_o) != (v.src + rd_k) % NW) addr_err++;
                rd_k++;
            end
            if (we_o) begin
                if (int'(waddr_o) != (v.dst + wr_k) % NW) addr_err++;
                if (wdata_o !== refm[(v.dst + wr_k) % NW]) data_err++;
                wr_k++;
            end
            if (done_o) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    tail = 2;
                end
            end
            @(negedge clk);
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
        chk($sformatf("v%0d busy_cycles", id), 64'(busy_n), 64'(v.exp_busy));
        chk($sformatf("v%0d overlap_cycles", id), 64'(ovl_n), 64'(v.exp_ovl));
        chk($sformatf("v%0d done_pulses", id), 64'(done_n), 64'd1);
        chk($sformatf("v%0d done_cycle", id), 64'(done_cyc), 64'(v.exp_busy + 1));
        chk($sformatf("v%0d writes", id), 64'(wr_k), 64'(ls));
        chk($sformatf("v%0d addr_errs", id), 64'(addr_err), 64'd0);
        chk($sformatf("v%0d wdata_errs", id), 64'(data_err), 64'd0);
        for (int i = 0; i < v.c_n; i++)
            chk($sformatf("v%0d mem[%0d]", id, (v.c_addr + i) % NW),
                64'(mem[(v.c_addr + i) % NW]), 64'(v.c_w[i]));
        cmp_image($sformatf("v%0d mem_image_diffs", id));
    endtask

    initial begin
        int busy_n, we_n, done_n;
        vecs[0] = mk(0, 100, 4, 0, 4, 32'hA, 32'hB, 32'hC, 32'hD, 5, 3, 100, 4,
                     32'hA, 32'hB, 32'hC, 32'hD);
        vecs[1] = mk(5, 6, 1, 5, 4, 32'h55, 32'h66, 32'h77, 32'h88, 2, 0, 6, 2,
                     32'h55, 32'h77, 32'h0, 32'h0);
        vecs[2] = mk(20, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30, 1,
                     32'h5A5A_001E, 32'h0, 32'h0, 32'h0);
        vecs[3] = mk(4094, 0, 4, 4094, 4, 32'h11, 32'h22, 32'h33, 32'h44, 5, 3, 0, 4,
                     32'h11, 32'h22, 32'h11, 32'h22);
        vecs[4] = mk(10, 11, 3, 10, 4, 32'h1, 32'h2, 32'h3, 32'h4, 4, 2, 10, 4,
                     32'h1, 32'h1, 32'h1, 32'h1);
        vecs[5] = mk(11, 10, 3, 10, 4, 32'h1, 32'h2, 32'h3, 32'h4, 4, 2, 10, 4,
                     32'h2, 32'h3, 32'h4, 32'h4);
        vecs[6] = mk(0, 0, 32'h1FFF, 0, 0, 0, 0, 0, 0, 4097, 4095, 0, 4,
                     32'h5A5A_0000, 32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003);

        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy_o", 64'(busy_o), 64'd0);
        chk("reset done_o", 64'(done_o), 64'd0);
        chk("reset re_we", 64'({re_o, we_o}), 64'd0);
        chk("reset addr_data", 64'({raddr_o, waddr_o, wdata_o}), 64'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // start_i held high for the whole copy must yield exactly one copy
        prep_mem(0, 0, '0);
        @(negedge clk);
        start_i = 1'b1; src_i = 12'd40; dst_i = 12'd200; len_i = 13'd2;
        busy_n = 0; we_n = 0; done_n = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (busy_o) busy_n++;
            if (we_o) we_n++;
            if (done_o) begin
                done_n++;
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        chk("hold busy_cycles", 64'(busy_n), 64'd3);
        chk("hold writes", 64'(we_n), 64'd2);
        chk("hold done_pulses", 64'(done_n), 64'd1);
        chk("hold mem[200]", 64'(mem[200]), 64'h5A5A_0028);
        chk("hold mem[201]", 64'(mem[201]), 64'h5A5A_0029);

        // Reset during RW aborts at once without a done pulse
        prep_mem(0, 0, '0);
        @(negedge clk);
        start_i = 1'b1; src_i = 12'd0; dst_i = 12'd300; len_i = 13'd4;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("abort in_rw", 64'({busy_o, re_o, we_o}), 64'b111);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("abort outputs", 64'({busy_o, re_o, we_o, done_o}), 64'd0);
        rst_ni = 1'b1;
        done_n = 0;
        busy_n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_o) done_n++;
            if (busy_o) busy_n++;
        end
        chk("abort no_done", 64'(done_n), 64'd0);
        chk("abort stays_idle", 64'(busy_n), 64'd0);
        chk("abort mem[300]", 64'(mem[300]), 64'h5A5A_0000);
        chk("abort mem[301]", 64'(mem[301]), 64'h5A5A_012D);

        run_vec(7, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
- Word-granular block-copy initiator that drives the read and write ports of the single-cycle `memory` block.
- Copies `len_i` words from `src_i` to `dst_i` as a two-stage pipeline: read word k while writing word k-1, which gives one word per cycle after a one-cycle fill.
- Sits between the control logic (or a CPU-side register interface) and `memory`.
- The final memory contents equal those of a sequential forward loop, including for overlapping ranges.

Parameters:
- NUMWORDS, 4096, memory depth in words; must match the attached `memory`.
- DATAWIDTH, 32, word width in bits.
- AW (localparam), $clog2(NUMWORDS), address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  request pulse; sampled only in IDLE.
- src_i  in  AW  source base word address.
- dst_i  in  AW  destination base word address.
- len_i  in  AW+1  word count; values above NUMWORDS saturate to NUMWORDS.
- busy_o  out  1  high while a copy is in progress.
- done_o  out  1  one-cycle pulse when a copy completes.
- re_o  out  1  memory read enable.
- raddr_o  out  AW  memory read address.
- rdata_i  in  DATAWIDTH  memory read data; combinational in the same cycle as raddr_o.
- we_o  out  1  memory write enable.
- waddr_o  out  AW  memory write address.
- wdata_o  out  DATAWIDTH  memory write data.

Behaviour:
- Reset: while rst_ni=0 at a clock edge, the state goes to IDLE and all counters and the data register clear. All outputs then read 0.
- States: IDLE, RD, RW, WR.
- IDLE:
  - start_i=1 and len_i!=0: latch src, dst and the saturated length into internal counters; go to RD.
  - start_i=1 and len_i=0: stay in IDLE; done_o=1 in the next cycle; no memory access.
- RD (fill):
  - re_o=1, raddr_o=src; we_o=0.
  - At the edge: capture rdata_i into the data register; src+=1; remaining-=1.
  - Next state: RW if remaining (before the decrement) > 1, else WR.
- RW (steady):
  - re_o=1, raddr_o=src, we_o=1, waddr_o=dst, wdata_o=data register.
  - At the edge: capture rdata_i; src+=1; dst+=1; remaining-=1.
  - Go to WR when the word read this cycle is the last one.
- WR (drain):
  - we_o=1, waddr_o=dst, wdata_o=data register; re_o=0.
  - Next: IDLE; done_o=1 in the following cycle.
- Outputs:
  - busy_o=1 in RD, RW and WR; 0 in IDLE.
  - done_o is a registered one-cycle pulse, asserted in the first IDLE cycle after WR (or after a zero-length start).
  - In IDLE, raddr_o, waddr_o and wdata_o are 0.
- Latency: N words take N+1 busy cycles; done_o follows one cycle after the last busy cycle.
- Address arithmetic: src and dst counters wrap modulo NUMWORDS (natural AW-bit overflow).
- Overlap: reading src+k while writing dst+k-1 in the same cycle relies on `memory` forwarding wdata when raddr==waddr. This makes the result identical to `for i: mem[dst+i]=mem[src+i]`. Consequences:
  - dst=src+1 propagates word src to the whole range (fill).
  - dst<src gives a correct move.
- start_i while busy_o=1: ignored; no queueing. Input changes on src_i, dst_i and len_i while busy have no effect.
- Reset mid-copy: the copy is aborted immediately and done_o is not pulsed. Memory keeps any words already written.

Decomposition:
- Package `dma_pkg`: state enum `dma_state_e` {IDLE, RD, RW, WR}.
- No sub-module. Address counters, remaining counter and data register stay inline; the block is about 150 lines.

Test Plan:
- Reset, then `memory` preloaded mem[0..3]={A,B,C,D}; start src=0 dst=100 len=4 → busy for 5 cycles, re/we overlap on cycles 2-4, done pulses once; mem[100..103]={A,B,C,D}.
- len=1, src=5 dst=6, mem[5]=0x55 → cycle 1 RD only, cycle 2 WR only, done in cycle 3; mem[6]=0x55.
- len=0 → no re_o/we_o activity, busy_o stays 0, done_o=1 exactly one cycle after start.
- Wrap: NUMWORDS=4096, src=4094 dst=0 len=4 → raddr sequence 4094, 4095, 0, 1; mem[0..3] equals the sequential-loop result (forwarded overlap).
- Overlap: mem[10..13]={1,2,3,4}, src=10 dst=11 len=3 → mem[11..13]={1,1,1}. Second case src=11 dst=10 len=3 → mem[10..12]={2,3,4}.
- Robustness:
  - start_i held high while busy → a single copy runs.
  - rst_ni=0 during RW → re_o=we_o=busy_o=0 the next cycle, no done pulse.
  - A later start works normally.
